// File: rtl/lc3b_mem_responder.sv
// Word-organized memory on the responder side of the LC-3b memory handshake.
// Each accepted request waits a configurable latency and is then acknowledged with a single mem_resp pulse.
`timescale 1ns/1ps
module lc3b_mem_responder #(
    parameter int ADDR_BITS     = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] READ_INIT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WRITE_INIT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state, state_next;
    logic [3:0]           count, count_next;
    logic [ADDR_BITS-1:0] addr_lat;
    logic [15:0]          wdata_lat;
    logic [1:0]           be_lat;
    logic                 write_lat;
    logic                 accept;
    logic                 commit;

    logic [ADDR_BITS-1:0] sel_addr;
    logic [15:0]          sel_wdata;
    logic [1:0]           sel_be;
    logic                 sel_write;

    logic [15:0] mem [DEPTH];

    // Only the word-index bits of the byte address select storage.
    logic unused_addr;
    assign unused_addr = &{1'b0, mem_address};

    assign accept = (state == IDLE) && (mem_read || mem_write);

    // A single-cycle latency commits straight out of IDLE, so use the live inputs there.
    assign sel_addr  = (state == IDLE) ? mem_address[ADDR_BITS:1] : addr_lat;
    assign sel_wdata = (state == IDLE) ? mem_wdata : wdata_lat;
    assign sel_be    = (state == IDLE) ? mem_byte_enable : be_lat;
    assign sel_write = (state == IDLE) ? mem_write : write_lat;

    always_comb begin
        state_next = state;
        count_next = count;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    count_next = mem_write ? WRITE_INIT : READ_INIT;
                    if (count_next == 4'd0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (write_lat ? !mem_write : !mem_read) begin
                    state_next = IDLE;
                    count_next = 4'd0;
                end else begin
                    count_next = count - 4'd1;
                    if (count_next == 4'd0) begin
                        state_next = RESP;
                        commit     = 1'b1;
                    end
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= 4'd0;
            addr_lat  <= '0;
            wdata_lat <= 16'h0000;
            be_lat    <= 2'b00;
            write_lat <= 1'b0;
            mem_rdata <= 16'h0000;
        end else begin
            state <= state_next;
            count <= count_next;
            if (accept) begin
                addr_lat  <= mem_address[ADDR_BITS:1];
                wdata_lat <= mem_wdata;
                be_lat    <= mem_byte_enable;
                write_lat <= mem_write;
            end
            if (commit && !sel_write) begin
                mem_rdata <= mem[sel_addr];
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive rst_n.
    always_ff @(posedge clk) begin
        if (commit && sel_write && rst_n) begin
            for (int b = 0; b < 2; b++) begin
                if (sel_be[b]) begin
                    mem[sel_addr][b*8 +: 8] <= sel_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign mem_resp = (state == RESP);

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Randomized bench for lc3b_mem_responder: a transaction-level model predicts the response cycle and read data.
`timescale 1ns/1ps
module tb_lc3b_mem_responder;
    localparam int AB = 8;
    localparam int RL = 3;
    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_address = 16'h0000;
    logic [15:0] mem_wdata = 16'h0000;
    logic [1:0]  mem_byte_enable = 2'b00;
    logic [15:0] mem_rdata;
    logic        mem_resp;

    lc3b_mem_responder #(
        .ADDR_BITS(AB),
        .READ_LATENCY(RL),
        .WRITE_LATENCY(WL)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .mem_address(mem_address),
        .mem_wdata(mem_wdata),
        .mem_byte_enable(mem_byte_enable),
        .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction model: memory image, pending response cycle and the read data it must carry.
    logic [15:0] model_mem [1 << AB];
    logic [15:0] exp_rdata = 16'h0000;
    logic [15:0] pend_rdata = 16'h0000;
    bit          pend_read = 1'b0;
    int          exp_resp_cyc = -1;
    int          last_resp = -100;
    int          prev_resp = -100;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc == exp_resp_cyc) begin
                if (pend_read) exp_rdata = pend_rdata;
                check16("resp_pulse", {15'd0, mem_resp}, 16'd1);
            end else begin
                check16("resp_quiet", {15'd0, mem_resp}, 16'd0);
            end
            check16("rdata", mem_rdata, exp_rdata);
            if (mem_resp) begin
                prev_resp = last_resp;
                last_resp = cyc;
            end
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] data, input logic [1:0] m,
                          output logic [15:0] got_data, output logic got_resp,
                          output logic got_resp_next, output int start_cyc);
        int lat;
        int idx;
        lat = wr ? WL : RL;
        idx = int'(addr[AB:1]);
        mem_read = rd;
        mem_write = wr;
        mem_address = addr;
        mem_wdata = data;
        mem_byte_enable = m;
        if (wr) begin
            for (int b = 0; b < 2; b++)
                if (m[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            pend_read = 1'b0;
        end else begin
            pend_read = 1'b1;
            pend_rdata = model_mem[idx];
        end
        start_cyc = cyc;
        exp_resp_cyc = cyc + lat;
        $display("txn cyc=%0d rd=%0d wr=%0d addr=%h data=%h mask=%b", cyc, rd, wr, addr, data, m);
        @(posedge clk); #1;
        // Disturb address/data while waiting: the accepted values must be the ones used.
        mem_address = 16'($urandom);
        mem_wdata = 16'($urandom);
        mem_byte_enable = 2'($urandom);
        repeat (lat - 1) @(posedge clk);
        #1;
        got_data = mem_rdata;
        got_resp = mem_resp;
        mem_read = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
        got_resp_next = mem_resp;
    endtask

    logic [15:0] d;
    logic        r, rn;
    int          s;

    task automatic wr16(input logic [15:0] addr, input logic [15:0] data, input logic [1:0] m);
        logic [15:0] dd; logic rr, rrn; int ss;
        access(1'b0, 1'b1, addr, data, m, dd, rr, rrn, ss);
    endtask

    initial begin
        #2;
        check16("reset_resp", {15'd0, mem_resp}, 16'd0);
        check16("reset_rdata", mem_rdata, 16'h0000);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < (1 << AB); i++) wr16(16'(i * 2), 16'($urandom), 2'b11);

        // Read latency and data
        wr16(16'h0040, 16'hBEEF, 2'b11);
        access(1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, d, r, rn, s);
        check16("lat_data", d, 16'hBEEF);
        check16("lat_resp", {15'd0, r}, 16'd1);
        check16("lat_resp_next", {15'd0, rn}, 16'd0);
        check16("lat_cycles", 16'(last_resp - s), 16'd3);

        // Full write, read with bit 0 set
        wr16(16'h0010, 16'h1234, 2'b11);
        access(1'b1, 1'b0, 16'h0011, 16'h0, 2'b00, d, r, rn, s);
        check16("full_wr", d, 16'h1234);

        // Byte writes
        wr16(16'h0020, 16'hAAAA, 2'b11);
        wr16(16'h0020, 16'h5566, 2'b10);
        access(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, d, r, rn, s);
        check16("byte_hi", d, 16'h55AA);
        wr16(16'h0020, 16'h7788, 2'b01);
        access(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, d, r, rn, s);
        check16("byte_lo", d, 16'h5588);
        access(1'b0, 1'b1, 16'h0020, 16'hFFFF, 2'b00, d, r, rn, s);
        check16("mask0_resp", {15'd0, r}, 16'd1);
        access(1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, d, r, rn, s);
        check16("mask0_data", d, 16'h5588);

        // Back-to-back indirect read
        wr16(16'h0008, 16'h0030, 2'b11);
        wr16(16'h0030, 16'hC0DE, 2'b11);
        access(1'b1, 1'b0, 16'h0008, 16'h0, 2'b00, d, r, rn, s);
        check16("b2b_first", d, 16'h0030);
        access(1'b1, 1'b0, d, 16'h0, 2'b00, d, r, rn, s);
        check16("b2b_second", d, 16'hC0DE);
        check16("b2b_spacing", 16'(last_resp - prev_resp), 16'd4);

        // Abort of a write
        wr16(16'h0050, 16'h1111, 2'b11);
        mem_write = 1'b1; mem_address = 16'h0050; mem_wdata = 16'h2222; mem_byte_enable = 2'b11;
        exp_resp_cyc = -1;
        $display("txn cyc=%0d abort write addr=0050", cyc);
        repeat (2) @(posedge clk);
        #1 mem_write = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        access(1'b1, 1'b0, 16'h0050, 16'h0, 2'b00, d, r, rn, s);
        check16("abort_mem", d, 16'h1111);

        // Simultaneous read and write acts as a write
        access(1'b1, 1'b1, 16'h0052, 16'h3333, 2'b11, d, r, rn, s);
        check16("simul_rdata", d, 16'h1111);
        access(1'b1, 1'b0, 16'h0052, 16'h0, 2'b00, d, r, rn, s);
        check16("simul_mem", d, 16'h3333);

        // Reset in the middle of a write
        wr16(16'h0060, 16'h4444, 2'b11);
        mem_write = 1'b1; mem_address = 16'h0060; mem_wdata = 16'h9999; mem_byte_enable = 2'b11;
        exp_resp_cyc = -1;
        $display("txn cyc=%0d reset during write addr=0060", cyc);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check16("rst_mid_resp", {15'd0, mem_resp}, 16'd0);
        check16("rst_mid_rdata", mem_rdata, 16'h0000);
        exp_rdata = 16'h0000;
        mem_write = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b1, 1'b0, 16'h0060, 16'h0, 2'b00, d, r, rn, s);
        check16("rst_mid_mem", d, 16'h4444);

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3)
                access(1'b1, 1'b0, 16'($urandom), 16'($urandom), 2'($urandom), d, r, rn, s);
            else if (op <= 7)
                access(1'b0, 1'b1, 16'($urandom), 16'($urandom), 2'($urandom), d, r, rn, s);
            else if (op == 8)
                access(1'b1, 1'b1, 16'($urandom), 16'($urandom), 2'($urandom), d, r, rn, s);
            else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
